// File: rtl/jtgng_rom_pkg.sv
// Shared constants for the ROM arbiter: client count, bus widths and FSM state encodings.
package jtgng_rom_pkg;

   localparam int NCLIENT = 4;
   localparam int AW      = 22;
   localparam int DW      = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   typedef logic [1:0] client_idx_t;

endpackage

// File: rtl/jtgng_rom_cache_entry.sv
// One-entry cache for a single ROM client: tag/data/valid, hit compare and registered ok.
module jtgng_rom_cache_entry
   import jtgng_rom_pkg::*;
(
   input  logic          clk,
   input  logic          srst,
   input  logic          inval,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          launch,
   input  logic          fill,
   input  logic [DW-1:0] fill_data,
   output logic          hit,
   output logic          ok,
   output logic [DW-1:0] dout
);

   logic [AW-1:0] tag_q;
   logic [DW-1:0] data_q;
   logic          valid_q;
   logic          ok_q;

   assign hit  = valid_q && (tag_q == addr);
   assign ok   = ok_q;
   assign dout = data_q;

   always_ff @(posedge clk) begin
      if (srst) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         ok_q <= cs && hit && !inval;
         // Launch drops valid so a stale word can never match the new tag before the fill.
         if (inval) begin
            valid_q <= 1'b0;
         end else if (launch) begin
            tag_q   <= addr;
            valid_q <= 1'b0;
         end else if (fill) begin
            data_q  <= fill_data;
            valid_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/jtgng_rom_arbiter.sv
// Four-client ROM read arbiter in front of the SDRAM controller.
// Define JTGNG_ROMARB_RR_EN for round-robin arbitration; fixed priority (0 highest) otherwise.
module jtgng_rom_arbiter
   import jtgng_rom_pkg::*;
#(
   parameter logic [21:0] OFFSET0 = 22'h00000,
   parameter logic [21:0] OFFSET1 = 22'h10000,
   parameter logic [21:0] OFFSET2 = 22'h20000,
   parameter logic [21:0] OFFSET3 = 22'h30000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  loop_rst,
   input  logic                  downloading,
   input  logic [NCLIENT-1:0]    req_cs,
   input  logic [NCLIENT*AW-1:0] req_addr,
   output logic [NCLIENT*DW-1:0] req_dout,
   output logic [NCLIENT-1:0]    req_ok,
   output logic                  read_req,
   output logic [AW-1:0]         sdram_addr,
   input  logic                  sdram_ack,
   input  logic [DW-1:0]         data_read,
   input  logic                  data_rdy,
   output logic                  refresh_en
);

   logic                 srst;
   logic [1:0]           state_q;
   client_idx_t          cur_q;
   logic                 read_req_q;
   logic [AW-1:0]        sdram_addr_q;
   logic                 refresh_q;
   logic [NCLIENT-1:0]   hit;
   logic [NCLIENT-1:0]   pending;
   logic [NCLIENT-1:0]   launch;
   logic [NCLIENT-1:0]   fill;
   logic                 any_pending;
   client_idx_t          win;
   logic [AW-1:0]        win_addr;
   logic [AW-1:0]        win_offset;

   assign srst        = rst | loop_rst;
   assign any_pending = |pending;
   assign read_req    = read_req_q;
   assign sdram_addr  = sdram_addr_q;
   assign refresh_en  = refresh_q;

   genvar gi;
   generate
      for (gi = 0; gi < NCLIENT; gi++) begin : g_client
         assign pending[gi] = req_cs[gi] && !hit[gi] && !downloading;
         assign launch[gi]  = (state_q == ST_IDLE) && any_pending && (win == client_idx_t'(gi));
         assign fill[gi]    = (state_q == ST_WAIT) && data_rdy && (cur_q == client_idx_t'(gi));

         jtgng_rom_cache_entry u_entry (
            .clk       (clk),
            .srst      (srst),
            .inval     (downloading),
            .cs        (req_cs[gi]),
            .addr      (req_addr[gi*AW +: AW]),
            .launch    (launch[gi]),
            .fill      (fill[gi]),
            .fill_data (data_read),
            .hit       (hit[gi]),
            .ok        (req_ok[gi]),
            .dout      (req_dout[gi*DW +: DW])
         );
      end
   endgenerate

`ifdef JTGNG_ROMARB_RR_EN
   client_idx_t last_q;

   // Search starts just after the previous winner so it ends up lowest priority.
   always_comb begin
      client_idx_t idx;
      logic        found;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NCLIENT; k++) begin
         idx = last_q + client_idx_t'(k);
         if (!found && pending[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         last_q <= 2'd3;
      end else if ((state_q == ST_IDLE) && any_pending) begin
         last_q <= win;
      end
   end
`else
   always_comb begin
      win = '0;
      for (int k = NCLIENT - 1; k >= 0; k--) begin
         if (pending[k]) win = client_idx_t'(k);
      end
   end
`endif

   always_comb begin
      win_addr = req_addr[win*AW +: AW];
      case (win)
         2'd0:    win_offset = OFFSET0;
         2'd1:    win_offset = OFFSET1;
         2'd2:    win_offset = OFFSET2;
         default: win_offset = OFFSET3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q      <= ST_IDLE;
         cur_q        <= '0;
         read_req_q   <= 1'b0;
         sdram_addr_q <= '0;
         refresh_q    <= 1'b1;
      end else begin
         refresh_q <= (state_q == ST_IDLE) && !any_pending;
         case (state_q)
            ST_IDLE: begin
               if (any_pending) begin
                  cur_q        <= win;
                  sdram_addr_q <= win_offset + win_addr;
                  read_req_q   <= 1'b1;
                  state_q      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (sdram_ack) begin
                  read_req_q <= 1'b0;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (data_rdy) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtgng_rom_arbiter.sv
// Directed self-checking bench for jtgng_rom_arbiter (OFFSET2 overridden to exercise the adder wrap).
module tb_jtgng_rom_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         loop_rst = 1'b0;
   logic         downloading = 1'b0;
   logic [3:0]   req_cs = '0;
   logic [87:0]  req_addr = '0;
   logic [127:0] req_dout;
   logic [3:0]   req_ok;
   logic         read_req;
   logic [21:0]  sdram_addr;
   logic         sdram_ack = 1'b0;
   logic [31:0]  data_read = '0;
   logic         data_rdy = 1'b0;
   logic         refresh_en;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   jtgng_rom_arbiter #(.OFFSET2(22'h3FFFF0)) dut (
      .clk         (clk),
      .rst         (rst),
      .loop_rst    (loop_rst),
      .downloading (downloading),
      .req_cs      (req_cs),
      .req_addr    (req_addr),
      .req_dout    (req_dout),
      .req_ok      (req_ok),
      .read_req    (read_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_read   (data_read),
      .data_rdy    (data_rdy),
      .refresh_en  (refresh_en)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, got);
      end
   endtask

   task automatic wait_req(input string tag, input logic [21:0] exp_addr);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!read_req && n < 20);
      check({tag, "_req"}, read_req, 1'b1);
      check({tag, "_addr"}, sdram_addr, exp_addr);
   endtask

   task automatic finish_xfer(input string tag, input logic [31:0] data);
      @(negedge clk);
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      check({tag, "_ackdrop"}, read_req, 1'b0);
      data_read = data;
      data_rdy  = 1'b1;
      @(negedge clk);
      data_rdy  = 1'b0;
   endtask

   task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [31:0] data);
      wait_req(tag, exp_addr);
      finish_xfer(tag, data);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_read_req", read_req, 1'b0);
      check("rst_sdram_addr", sdram_addr, 22'h0);
      check("rst_ok", req_ok, 4'h0);
      check("rst_dout", req_dout, 128'h0);
      check("rst_refresh", refresh_en, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // First miss on client 0, then fill
      req_addr[21:0] = 22'h123;
      req_cs[0] = 1'b1;
      wait_req("c0", 22'h123);
      check("c0_refresh_busy", refresh_en, 1'b0);
      finish_xfer("c0", 32'hDEADBEEF);
      check("c0_ok_latency", req_ok[0], 1'b0);
      @(negedge clk);
      check("c0_ok", req_ok[0], 1'b1);
      check("c0_dout", req_dout[31:0], 32'hDEADBEEF);
      check("c0_no_rereq", read_req, 1'b0);

      // Hit after cs toggle
      req_cs[0] = 1'b0;
      @(negedge clk);
      check("hit_ok_drop", req_ok[0], 1'b0);
      req_cs[0] = 1'b1;
      @(negedge clk);
      check("hit_ok", req_ok[0], 1'b1);
      check("hit_no_req", read_req, 1'b0);
      req_cs[0] = 1'b0;

      // Client 1 alone, then simultaneous client 1 and 3 misses
      req_addr[43:22] = 22'h44;
      req_cs[1] = 1'b1;
      serve("c1a", 22'h10044, 32'h11111111);
      @(negedge clk);
      check("c1a_ok", req_ok[1], 1'b1);
      check("c1a_dout", req_dout[63:32], 32'h11111111);
      req_addr[43:22] = 22'h45;
      req_addr[87:66] = 22'h5;
      req_cs[3] = 1'b1;
`ifdef JTGNG_ROMARB_RR_EN
      serve("arb_first", 22'h30005, 32'h33333333);
      serve("arb_second", 22'h10045, 32'h11112222);
`else
      serve("arb_first", 22'h10045, 32'h11112222);
      serve("arb_second", 22'h30005, 32'h33333333);
`endif
      @(negedge clk);
      check("arb_ok", req_ok, 4'b1010);
      check("arb_dout3", req_dout[127:96], 32'h33333333);
      check("arb_dout1", req_dout[63:32], 32'h11112222);

      // Downloading invalidates both entries and blocks requests
      downloading = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("dl_ok", req_ok, 4'h0);
         check("dl_no_req", read_req, 1'b0);
      end
      downloading = 1'b0;
`ifdef JTGNG_ROMARB_RR_EN
      serve("dl_refetch_a", 22'h30005, 32'h33334444);
      serve("dl_refetch_b", 22'h10045, 32'h11113333);
`else
      serve("dl_refetch_a", 22'h10045, 32'h11113333);
      serve("dl_refetch_b", 22'h30005, 32'h33334444);
`endif
      @(negedge clk);
      check("dl_refetch_ok", req_ok, 4'b1010);
      req_cs = '0;

      // Reset in WAIT discards the transfer
      req_addr[65:44] = 22'h7;
      req_cs[2] = 1'b1;
      wait_req("rw", 22'h3FFFF7);
      @(negedge clk);
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      rst = 1'b1;
      req_cs[2] = 1'b0;
      @(negedge clk);
      check("rw_read_req", read_req, 1'b0);
      check("rw_refresh", refresh_en, 1'b1);
      check("rw_sdram_addr", sdram_addr, 22'h0);
      check("rw_ok", req_ok, 4'h0);
      rst = 1'b0;
      @(negedge clk);
      data_read = 32'h55555555;
      data_rdy  = 1'b1;
      @(negedge clk);
      data_rdy  = 1'b0;
      @(negedge clk);
      check("rw_late_ok", req_ok, 4'h0);
      check("rw_late_dout", req_dout[95:64], 32'h0);
      check("rw_late_idle", read_req, 1'b0);
      req_cs[2] = 1'b1;
      serve("rw_refetch", 22'h3FFFF7, 32'h22222222);
      req_cs[2] = 1'b0;
      @(negedge clk);

      // Offset adder wraps
      req_addr[65:44] = 22'h20;
      req_cs[2] = 1'b1;
      serve("wrap", 22'h000010, 32'hCAFEF00D);
      @(negedge clk);
      check("wrap_ok", req_ok[2], 1'b1);
      check("wrap_dout", req_dout[95:64], 32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
